// File: rtl/track_pkg.sv
// Shared definitions for the object-tracking frame controller: FSM states,
// nominal frame geometry and the "no match" position value.
package track_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DIV   = 3'd3,
    LATCH = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int          FRAME_W   = 640;
  localparam int          FRAME_H   = 480;
  localparam logic [31:0] NOT_FOUND = 32'hFFFF_FFFF;

endpackage

// File: rtl/track_ctrl.sv
// Frame-level control FSM for the centroid tracking datapath.
// Optional build macro TRACK_CTRL_IRQ_EN adds a sticky frame-done interrupt.
module track_ctrl
  import track_pkg::*;
#(
  parameter int DIV_WAIT = 4,
  parameter int ID_W     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic abort,
  input  logic continuous,
  input  logic pixel_valid,
  output logic pixel_ready,
  input  logic x_eq_640,
  input  logic y_eq_480,
  input  logic count_ne_0,
  input  logic found,
  output logic reset_x,
  output logic reset_y,
  output logic reset_x_sum,
  output logic reset_y_sum,
  output logic reset_count,
  output logic reset_x_pos,
  output logic reset_y_pos,
  output logic enable_x,
  output logic enable_y,
  output logic enable_x_sum,
  output logic enable_y_sum,
  output logic enable_count,
  output logic enable_x_pos,
  output logic enable_y_pos,
  output logic sel,
  output logic busy,
  output logic frame_done
`ifdef TRACK_CTRL_IRQ_EN
  ,
  output logic irq,
  input  logic irq_clear
`endif
);

  localparam logic [ID_W-1:0] WAIT_LAST = ID_W'(DIV_WAIT - 1);

  state_t          state, next_state;
  logic [ID_W-1:0] wait_cnt, wait_cnt_next;
  logic            abort_pend, abort_pend_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      abort_pend <= 1'b0;
    end else begin
      state      <= next_state;
      wait_cnt   <= wait_cnt_next;
      abort_pend <= abort_pend_next;
    end
  end

  always_comb begin
    next_state      = state;
    wait_cnt_next   = '0;
    abort_pend_next = 1'b0;
    pixel_ready     = 1'b0;
    reset_x         = 1'b0;
    reset_y         = 1'b0;
    reset_x_sum     = 1'b0;
    reset_y_sum     = 1'b0;
    reset_count     = 1'b0;
    reset_x_pos     = 1'b0;
    reset_y_pos     = 1'b0;
    enable_x        = 1'b0;
    enable_y        = 1'b0;
    enable_x_sum    = 1'b0;
    enable_y_sum    = 1'b0;
    enable_count    = 1'b0;
    enable_x_pos    = 1'b0;
    enable_y_pos    = 1'b0;
    sel             = 1'b0;
    frame_done      = 1'b0;
    busy            = (state != IDLE);

    if (reset) begin
      reset_x     = 1'b1;
      reset_y     = 1'b1;
      reset_x_sum = 1'b1;
      reset_y_sum = 1'b1;
      reset_count = 1'b1;
      reset_x_pos = 1'b1;
      reset_y_pos = 1'b1;
      busy        = 1'b0;
    end else if (abort) begin
      // Abort wins over everything; the pending flag routes CLEAR back to IDLE.
      if (state != IDLE) begin
        next_state      = CLEAR;
        abort_pend_next = 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) next_state = CLEAR;
        end
        CLEAR: begin
          reset_x     = 1'b1;
          reset_y     = 1'b1;
          reset_x_sum = 1'b1;
          reset_y_sum = 1'b1;
          reset_count = 1'b1;
          next_state  = abort_pend ? IDLE : RUN;
        end
        RUN: begin
          pixel_ready = 1'b1;
          if (pixel_valid) begin
            enable_x = 1'b1;
            if (found) begin
              enable_x_sum = 1'b1;
              enable_y_sum = 1'b1;
              enable_count = 1'b1;
            end
            // End of line: the datapath gives reset_x priority over enable_x.
            if (x_eq_640) begin
              reset_x  = 1'b1;
              enable_y = 1'b1;
              if (y_eq_480) begin
                reset_y    = 1'b1;
                next_state = DIV;
              end
            end
          end
        end
        DIV: begin
          if (wait_cnt == WAIT_LAST) next_state = LATCH;
          else wait_cnt_next = wait_cnt + 1'b1;
        end
        LATCH: begin
          enable_x_pos = 1'b1;
          enable_y_pos = 1'b1;
          sel          = ~count_ne_0;
          next_state   = DONE;
        end
        DONE: begin
          frame_done = 1'b1;
          next_state = continuous ? CLEAR : IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

`ifdef TRACK_CTRL_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset)           irq <= 1'b0;
    else if (frame_done) irq <= 1'b1;
    else if (irq_clear)  irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_track_ctrl.sv
// Bench for track_ctrl: a small behavioural datapath closes the loop, and
// results are compared against centroids computed directly from the target list.
module tb_track_ctrl;
  import track_pkg::*;

  localparam int DW   = 4;
  localparam int IW   = 4;
  localparam int FW   = 32;
  localparam int FH   = 24;
  localparam int NPIX = FW * FH;

  logic clk = 1'b0;
  logic reset, start, abort, continuous, pixel_valid, pixel_ready;
  logic x_eq_640, y_eq_480, count_ne_0, found;
  logic reset_x, reset_y, reset_x_sum, reset_y_sum, reset_count, reset_x_pos, reset_y_pos;
  logic enable_x, enable_y, enable_x_sum, enable_y_sum, enable_count, enable_x_pos, enable_y_pos;
  logic sel, busy, frame_done;
`ifdef TRACK_CTRL_IRQ_EN
  logic irq, irq_clear;
`endif

  always #5 clk = ~clk;

  track_ctrl #(.DIV_WAIT(DW), .ID_W(IW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .continuous(continuous),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .x_eq_640(x_eq_640), .y_eq_480(y_eq_480), .count_ne_0(count_ne_0), .found(found),
    .reset_x(reset_x), .reset_y(reset_y), .reset_x_sum(reset_x_sum), .reset_y_sum(reset_y_sum),
    .reset_count(reset_count), .reset_x_pos(reset_x_pos), .reset_y_pos(reset_y_pos),
    .enable_x(enable_x), .enable_y(enable_y), .enable_x_sum(enable_x_sum),
    .enable_y_sum(enable_y_sum), .enable_count(enable_count),
    .enable_x_pos(enable_x_pos), .enable_y_pos(enable_y_pos),
    .sel(sel), .busy(busy), .frame_done(frame_done)
`ifdef TRACK_CTRL_IRQ_EN
    , .irq(irq), .irq_clear(irq_clear)
`endif
  );

  // Behavioural datapath on a reduced FW x FH frame
  int          x, y, x_sum, y_sum, cnt;
  logic [31:0] x_pos, y_pos;
  bit          tgt [NPIX];
  int          tq_x[$], tq_y[$];

  assign x_eq_640   = (x == FW - 1);
  assign y_eq_480   = (y == FH - 1);
  assign count_ne_0 = (cnt != 0);
  assign found      = (x >= 0 && x < FW && y >= 0 && y < FH) ? tgt[y*FW + x] : 1'b0;

  always @(posedge clk) begin
    if (reset_x) x <= 0; else if (enable_x) x <= x + 1;
    if (reset_y) y <= 0; else if (enable_y) y <= y + 1;
    if (reset_x_sum) x_sum <= 0; else if (enable_x_sum) x_sum <= x_sum + x;
    if (reset_y_sum) y_sum <= 0; else if (enable_y_sum) y_sum <= y_sum + y;
    if (reset_count) cnt <= 0; else if (enable_count) cnt <= cnt + 1;
    if (reset_x_pos) x_pos <= 32'd0;
    else if (enable_x_pos) x_pos <= sel ? NOT_FOUND : ((cnt != 0) ? 32'(x_sum / cnt) : 32'd0);
    if (reset_y_pos) y_pos <= 32'd0;
    else if (enable_y_pos) y_pos <= sel ? NOT_FOUND : ((cnt != 0) ? 32'(y_sum / cnt) : 32'd0);
  end

  // Monitors
  int cyc = 0, acc_cnt = 0, last_acc_cyc = 0, done_cnt = 0, done_cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pixel_valid && pixel_ready) begin
      acc_cnt      <= acc_cnt + 1;
      last_acc_cyc <= cyc;
    end
    if (frame_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  int n_pass = 0, n_total = 0;

  task automatic clear_targets();
    tq_x.delete();
    tq_y.delete();
    for (int i = 0; i < NPIX; i++) tgt[i] = 1'b0;
  endtask

  task automatic add_target(input int tx, input int ty);
    if (!tgt[ty*FW + tx]) begin
      tgt[ty*FW + tx] = 1'b1;
      tq_x.push_back(tx);
      tq_y.push_back(ty);
    end
  endtask

  // Expected centroid straight from the target list
  function automatic logic [31:0] ref_avg(input bit want_y);
    int s;
    s = 0;
    if (tq_x.size() == 0) return NOT_FOUND;
    for (int i = 0; i < tq_x.size(); i++) s += want_y ? tq_y[i] : tq_x[i];
    return 32'(s / tq_x.size());
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start       = 1'($urandom_range(1));
      abort       = 1'($urandom_range(1));
      continuous  = 1'($urandom_range(1));
      pixel_valid = 1'($urandom_range(1));
      #1;
      n_total++;
      if ({reset_x, reset_y, reset_x_sum, reset_y_sum, reset_count, reset_x_pos, reset_y_pos} !== 7'h7F)
        $display("FAIL reset_clears: got %b expected 1111111",
                 {reset_x, reset_y, reset_x_sum, reset_y_sum, reset_count, reset_x_pos, reset_y_pos});
      else n_pass++;
      n_total++;
      if ({enable_x, enable_y, enable_x_sum, enable_y_sum, enable_count, enable_x_pos, enable_y_pos, sel} !== 8'h00)
        $display("FAIL reset_enables: got %b expected 00000000",
                 {enable_x, enable_y, enable_x_sum, enable_y_sum, enable_count, enable_x_pos, enable_y_pos, sel});
      else n_pass++;
      n_total++;
      if ({pixel_ready, busy, frame_done} !== 3'b000)
        $display("FAIL reset_status: got %b expected 000", {pixel_ready, busy, frame_done});
      else n_pass++;
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0; abort = 1'b0; continuous = 1'b0; pixel_valid = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    n_total++;
    if ({busy, pixel_ready} !== 2'b00)
      $display("FAIL idle_after_reset: got busy,ready=%b expected 00", {busy, pixel_ready});
    else n_pass++;
    n_total++;
    if (acc_cnt !== 0) $display("FAIL idle_no_accept: got %0d expected 0", acc_cnt);
    else n_pass++;
`ifdef TRACK_CTRL_IRQ_EN
    n_total++;
    if (irq !== 1'b0) $display("FAIL irq_reset: got %b expected 0", irq);
    else n_pass++;
`endif
    pixel_valid = 1'b0;
  endtask

  // One complete frame with the current target set
  task automatic test_frame(input string tag, input int duty, input bit noise);
    int base_acc, base_done, n;
    logic [31:0] ex, ey;
    ex = ref_avg(1'b0);
    ey = ref_avg(1'b1);
    base_acc  = acc_cnt;
    base_done = done_cnt;
    n = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    n_total++;
    if ({reset_x, reset_y, reset_x_sum, reset_y_sum, reset_count, reset_x_pos, reset_y_pos, busy, pixel_ready} !== 9'b111110010)
      $display("FAIL %s clear_state: got %b expected 111110010", tag,
               {reset_x, reset_y, reset_x_sum, reset_y_sum, reset_count, reset_x_pos, reset_y_pos, busy, pixel_ready});
    else n_pass++;
    while (done_cnt == base_done && n < 20 * NPIX) begin
      pixel_valid = ($urandom_range(99) < 32'(duty));
      if (noise) start = 1'($urandom_range(1));
      @(negedge clk);
      n++;
    end
    pixel_valid = 1'b0;
    start = 1'b0;
    n_total++;
    if (done_cnt == base_done) $display("FAIL %s timeout: no frame_done after %0d cycles", tag, n);
    else n_pass++;
    n_total++;
    if (acc_cnt - base_acc !== NPIX) $display("FAIL %s accepted: got %0d expected %0d", tag, acc_cnt - base_acc, NPIX);
    else n_pass++;
    n_total++;
    if (done_cyc - last_acc_cyc !== DW + 2)
      $display("FAIL %s latency: got %0d expected %0d", tag, done_cyc - last_acc_cyc, DW + 2);
    else n_pass++;
    n_total++;
    if (x_pos !== ex) $display("FAIL %s x_pos: got %h expected %h", tag, x_pos, ex);
    else n_pass++;
    n_total++;
    if (y_pos !== ey) $display("FAIL %s y_pos: got %h expected %h", tag, y_pos, ey);
    else n_pass++;
`ifdef TRACK_CTRL_IRQ_EN
    n_total++;
    if (irq !== 1'b1) $display("FAIL %s irq_set: got %b expected 1", tag, irq);
    else n_pass++;
`endif
    @(negedge clk); #1;
    n_total++;
    if (done_cnt - base_done !== 1) $display("FAIL %s done_pulses: got %0d expected 1", tag, done_cnt - base_done);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL %s back_to_idle: got busy=%b expected 0", tag, busy);
    else n_pass++;
  endtask

  task automatic test_single_pixel();
    clear_targets();
    add_target(10, 20);
    test_frame("single", 100, 1'b0);
  endtask

  task automatic test_no_match();
    clear_targets();
    test_frame("none", 100, 1'b0);
    n_total++;
    if (cnt !== 0) $display("FAIL none_count: got %0d expected 0", cnt);
    else n_pass++;
  endtask

  task automatic test_two_pixels_stall();
    clear_targets();
    add_target(5, 3);
    add_target(25, 17);
    test_frame("two_stall", 50, 1'b0);
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 3; f++) begin
      clear_targets();
      for (int k = 0; k < int'($urandom_range(6, 1)); k++)
        add_target(int'($urandom_range(FW - 1)), int'($urandom_range(FH - 1)));
      test_frame("random", int'($urandom_range(100, 30)), 1'b1);
    end
  endtask

  task automatic test_abort();
    int base_acc, base_done, n, acc_at_abort;
    logic [31:0] old_x;
    clear_targets();
    add_target(1, 0);
    old_x     = x_pos;
    base_acc  = acc_cnt;
    base_done = done_cnt;
    n = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (acc_cnt - base_acc < 100 && n < 1000) begin
      pixel_valid = 1'b1;
      @(negedge clk);
      n++;
    end
    n_total++;
    if (acc_cnt - base_acc !== 100) $display("FAIL abort_reach: got %0d expected 100", acc_cnt - base_acc);
    else n_pass++;
    abort = 1'b1;
    start = 1'b1;
    acc_at_abort = acc_cnt;
    #1;
    n_total++;
    if (pixel_ready !== 1'b0) $display("FAIL abort_ready: got %b expected 0", pixel_ready);
    else n_pass++;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    pixel_valid = 1'b0;
    #1;
    n_total++;
    if ({busy, reset_count, reset_x_pos, enable_x} !== 4'b1100)
      $display("FAIL abort_clear: got busy,rcnt,rxpos,enx=%b expected 1100", {busy, reset_count, reset_x_pos, enable_x});
    else n_pass++;
    n_total++;
    if (acc_cnt !== acc_at_abort) $display("FAIL abort_consumed: got %0d expected %0d", acc_cnt, acc_at_abort);
    else n_pass++;
    @(negedge clk); #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL abort_idle: got busy=%b expected 0", busy);
    else n_pass++;
    repeat (DW + 4) @(negedge clk);
    n_total++;
    if (done_cnt !== base_done) $display("FAIL abort_no_done: got %0d expected %0d", done_cnt, base_done);
    else n_pass++;
    n_total++;
    if (x_pos !== old_x) $display("FAIL abort_x_pos: got %h expected %h", x_pos, old_x);
    else n_pass++;
    clear_targets();
    add_target(12, 7);
    test_frame("after_abort", 100, 1'b0);
  endtask

  task automatic test_continuous();
    int base_acc, base_done, n;
    clear_targets();
    add_target(3, 4);
    base_acc  = acc_cnt;
    base_done = done_cnt;
    n = 0;
    continuous = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (done_cnt == base_done && n < 10 * NPIX) begin
      pixel_valid = 1'($urandom_range(1));
      @(negedge clk);
      n++;
    end
    pixel_valid = 1'b0;
    #1;
    n_total++;
    if ({x_pos, y_pos} !== {32'd3, 32'd4}) $display("FAIL cont_first: got %0d,%0d expected 3,4", x_pos, y_pos);
    else n_pass++;
    n_total++;
    if ({busy, reset_count} !== 2'b11) $display("FAIL cont_reclear: got busy,rcnt=%b expected 11", {busy, reset_count});
    else n_pass++;
    clear_targets();
    add_target(7, 9);
    add_target(9, 11);
    continuous = 1'b0;
    n = 0;
    while (done_cnt == base_done + 1 && n < 10 * NPIX) begin
      pixel_valid = 1'($urandom_range(1));
      @(negedge clk);
      n++;
    end
    pixel_valid = 1'b0;
    @(negedge clk); #1;
    n_total++;
    if (done_cnt - base_done !== 2) $display("FAIL cont_pulses: got %0d expected 2", done_cnt - base_done);
    else n_pass++;
    n_total++;
    if ({x_pos, y_pos} !== {32'd8, 32'd10}) $display("FAIL cont_second: got %0d,%0d expected 8,10", x_pos, y_pos);
    else n_pass++;
    n_total++;
    if (acc_cnt - base_acc !== 2 * NPIX) $display("FAIL cont_accepted: got %0d expected %0d", acc_cnt - base_acc, 2 * NPIX);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL cont_stop: got busy=%b expected 0", busy);
    else n_pass++;
  endtask

`ifdef TRACK_CTRL_IRQ_EN
  task automatic test_irq();
    @(negedge clk);
    irq_clear = 1'b1;
    @(negedge clk); #1;
    n_total++;
    if (irq !== 1'b0) $display("FAIL irq_clear: got %b expected 0", irq);
    else n_pass++;
    clear_targets();
    add_target(2, 2);
    test_frame("irq_set_wins", 100, 1'b0);
    irq_clear = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0; pixel_valid = 1'b0;
`ifdef TRACK_CTRL_IRQ_EN
    irq_clear = 1'b0;
`endif
    test_reset();
    test_single_pixel();
    test_no_match();
    test_two_pixels_stall();
    test_random_frames();
    test_abort();
    test_continuous();
`ifdef TRACK_CTRL_IRQ_EN
    test_irq();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/track_ctrl.md
TRACK_CTRL -- requirements
Module: track_ctrl

Interface
REQ-001 SHALL have parameter DIV_WAIT, default 4: cycles allowed for the datapath combinational divide before latching (range 1..15).
REQ-002 SHALL have parameter ID_W, default 4: width of the wait counter.
REQ-003 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports start, abort, continuous  in  1 each: start a frame; abandon the frame; auto-restart after each frame.
REQ-006 SHALL have ports pixel_valid  in  1 and pixel_ready  out  1: pixel handshake; a pixel is accepted when both are high.
REQ-007 SHALL have ports x_eq_640, y_eq_480, count_ne_0, found  in  1 each: datapath status flags.
REQ-008 SHALL have outputs reset_x, reset_y, reset_x_sum, reset_y_sum, reset_count, reset_x_pos, reset_y_pos  out  1 each: datapath clears.
REQ-009 SHALL have outputs enable_x, enable_y, enable_x_sum, enable_y_sum, enable_count, enable_x_pos, enable_y_pos, sel  out  1 each: datapath enables and the "not found" select.
REQ-010 SHALL have outputs busy  out  1 and frame_done  out  1: busy is high outside IDLE; frame_done is a one-cycle pulse.

Function
REQ-011 SHALL implement the states IDLE, CLEAR, RUN, DIV, LATCH and DONE.
REQ-012 IDLE: start=1 SHALL move to CLEAR; otherwise remain in IDLE.
REQ-013 CLEAR (1 cycle): SHALL assert reset_x, reset_y, reset_x_sum, reset_y_sum and reset_count, then move to RUN.
REQ-014 RUN: pixel_ready=1; on each accepted pixel enable_x=1, and if found=1 also enable_x_sum=enable_y_sum=enable_count=1 in the same cycle.
REQ-015 RUN, accepted pixel with x_eq_640=1: SHALL assert reset_x and enable_y (reset_x has priority over enable_x in the datapath).
REQ-016 RUN, accepted pixel with x_eq_640=1 and y_eq_480=1: SHALL also assert reset_y, then move to DIV.
REQ-017 RUN, pixel_valid=0: SHALL assert no enables and hold state (stalls of any length allowed).
REQ-018 DIV: SHALL hold exactly DIV_WAIT cycles using the wait counter, all enables low, pixel_ready=0, then move to LATCH.
REQ-019 LATCH (1 cycle): SHALL assert enable_x_pos=enable_y_pos=1 with sel=~count_ne_0, so that zero matches latch 0xFFFFFFFF, then move to DONE.
REQ-020 DONE (1 cycle): frame_done=1; next state SHALL be CLEAR if continuous=1, else IDLE.
REQ-021 Frame latency: from the last accepted pixel to frame_done SHALL be DIV_WAIT+2 cycles.
REQ-022 abort=1 in any non-IDLE state SHALL move to CLEAR's clears for one cycle and then to IDLE; x_pos/y_pos are not updated and frame_done is not pulsed.
REQ-023 abort has priority over start and pixel acceptance in the same cycle; start is ignored outside IDLE.
REQ-024 pixel_ready SHALL be 0 in every state except RUN; pixels offered outside RUN are not consumed.

Reset
REQ-025 While reset=1, all seven reset_* outputs SHALL be 1 (combinationally), all enables, sel, pixel_ready, busy and frame_done SHALL be 0, state SHALL become IDLE and the wait counter 0.

Configuration
REQ-026 With TRACK_CTRL_IRQ_EN defined, SHALL add ports irq out 1 and irq_clear in 1.
REQ-027 irq SHALL set on frame_done and clear on irq_clear; set wins if both occur in the same cycle; reset value 0.
REQ-028 Without TRACK_CTRL_IRQ_EN, those ports SHALL be absent and behaviour otherwise identical.

Structure
REQ-029 A shared package track_pkg SHALL hold the state enum, FRAME_W=640, FRAME_H=480 and NOT_FOUND=32'hFFFFFFFF.
REQ-030 The block SHALL be one FSM module with no sub-module; the wait counter is inline.

Verification (bench drives datapath + track_ctrl)
REQ-031 Single found pixel at x=10, y=20 in a 640x480 frame: x_pos=10, y_pos=20, frame_done DIV_WAIT+2 cycles after pixel 307200.
REQ-032 No found pixels: x_pos=y_pos=0xFFFFFFFF, count stays 0.
REQ-033 Found pixels at (100,50) and (200,150), pixel_valid randomly 50% duty: x_pos=150, y_pos=100, exactly 307200 pixels accepted.
REQ-034 abort at pixel 1000: returns to IDLE within 2 cycles, no frame_done, x_pos unchanged; next start yields a correct frame.
REQ-035 continuous=1 for 2 frames: two frame_done pulses, CLEAR between frames, second result independent of the first.
REQ-036 TRACK_CTRL_IRQ_EN: irq rises with frame_done; irq_clear and frame_done in the same cycle leave irq=1.
